// File: rtl/k12a_stack_unit_pkg.sv
// k12a stack unit shared types.
// Frame sequencer state encoding.
package k12a_stack_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FPUSH,
        FPOP,
        DONE
    } stack_state_t;

endpackage

// File: rtl/k12a_stack_bounds.sv
// k12a stack bounds checker.
// Room below sp and data above sp, both against a word count.
module k12a_stack_bounds #(
    parameter int unsigned        WIDTH       = 16,
    parameter logic [WIDTH-1:0]   STACK_BASE  = 16'h0000,
    parameter logic [WIDTH-1:0]   STACK_LIMIT = 16'hF000,
    parameter int unsigned        STEP        = 1
) (
    input  logic [WIDTH-1:0] sp,
    input  logic [WIDTH-1:0] words,
    output logic             room_ok,
    output logic             data_ok
);

    logic [WIDTH-1:0] need;
    logic [WIDTH-1:0] room;
    logic [WIDTH-1:0] data;

    // Distances are modulo 2^WIDTH so a wrapped base still works.
    assign need    = words * WIDTH'(STEP);
    assign room    = sp - STACK_LIMIT;
    assign data    = STACK_BASE - sp;
    assign room_ok = (room >= need);
    assign data_ok = (data >= need);

endmodule

// File: rtl/k12a_stack_unit.sv
// k12a stack unit: SP register, push/pop, bounds flags,
// and a multi-word frame sequencer.
module k12a_stack_unit
    import k12a_stack_unit_pkg::*;
#(
    parameter int unsigned        WIDTH       = 16,
    parameter logic [WIDTH-1:0]   STACK_BASE  = 16'h0000,
    parameter logic [WIDTH-1:0]   STACK_LIMIT = 16'hF000,
    parameter int unsigned        STEP        = 1,
    parameter int unsigned        FRAME_WORDS = 4
) (
    input  logic                           cpu_clock,
    input  logic                           reset_n,
    input  logic                           sp_load,
    input  logic                           sp_store,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           frame_push_start,
    input  logic                           frame_pop_start,
    input  logic                           frame_ready,
    input  logic                           fault_clear,
    inout  wire  [WIDTH-1:0]               addr_bus,
    output logic [WIDTH-1:0]               sp,
    output logic [WIDTH-1:0]               stack_addr,
    output logic [WIDTH-1:0]               frame_addr,
    output logic [$clog2(FRAME_WORDS)-1:0] frame_idx,
    output logic                           frame_valid,
    output logic                           frame_write,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           ovf,
    output logic                           udf
);

    localparam int unsigned      IDX_W    = $clog2(FRAME_WORDS);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] FRAME_W  = WIDTH'(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    // A full frame must fit between the limit and the base.
    if (FRAME_WORDS < 2 ||
        WIDTH'(STACK_BASE - STACK_LIMIT) < WIDTH'(FRAME_WORDS * STEP))
    begin : g_bad_params
        $error("k12a_stack_unit: illegal stack geometry");
    end

    stack_state_t     state_q;
    stack_state_t     state_d;
    logic [WIDTH-1:0] sp_q;
    logic [WIDTH-1:0] sp_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;
    logic             ovf_set;
    logic             udf_set;
    logic             one_room;
    logic             one_data;
    logic             frm_room;
    logic             frm_data;

    k12a_stack_bounds #(
        .WIDTH       (WIDTH),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT),
        .STEP        (STEP)
    ) u_word_bounds (
        .sp      (sp_q),
        .words   (ONE_W),
        .room_ok (one_room),
        .data_ok (one_data)
    );

    k12a_stack_bounds #(
        .WIDTH       (WIDTH),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT),
        .STEP        (STEP)
    ) u_frame_bounds (
        .sp      (sp_q),
        .words   (FRAME_W),
        .room_ok (frm_room),
        .data_ok (frm_data)
    );

    assign addr_bus    = sp_load ? sp_q : 'z;
    assign sp          = sp_q;
    assign stack_addr  = push ? (sp_q - STEP_W) : sp_q;
    assign frame_addr  = (state_q == FPUSH) ? (sp_q - STEP_W) : sp_q;
    assign frame_idx   = idx_q;
    assign frame_valid = (state_q == FPUSH) || (state_q == FPOP);
    assign frame_write = (state_q == FPUSH);
    assign frame_done  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign ovf         = ovf_q;
    assign udf         = udf_q;

    // Next state: bus store, then flags, then frame FSM, then push/pop.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;

        if (fault_clear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (sp_store) begin
            sp_d    = addr_bus;
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_push_start) begin
                        if (!frm_room) begin
                            ovf_set = 1'b1;
                        end else begin
                            state_d = FPUSH;
                            idx_d   = '0;
                        end
                    end else if (frame_pop_start) begin
                        if (!frm_data) begin
                            udf_set = 1'b1;
                        end else begin
                            state_d = FPOP;
                            idx_d   = '0;
                        end
                    end else if (push && !pop) begin
                        if (!one_room) begin
                            ovf_set = 1'b1;
                        end else begin
                            sp_d = sp_q - STEP_W;
                        end
                    end else if (pop && !push) begin
                        if (!one_data) begin
                            udf_set = 1'b1;
                        end else begin
                            sp_d = sp_q + STEP_W;
                        end
                    end
                end
                FPUSH, FPOP: begin
                    if (frame_ready) begin
                        sp_d = (state_q == FPUSH) ? (sp_q - STEP_W)
                                                  : (sp_q + STEP_W);
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (udf_set) begin
            udf_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge cpu_clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sp_q    <= STACK_BASE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

endmodule

// File: tb/tb_k12a_stack_unit.sv
// Self-checking bench for k12a_stack_unit.
// Directed literal checks plus randomized run against a behavioural model.
module tb_k12a_stack_unit;

    localparam logic [15:0] BASE  = 16'h0100;
    localparam logic [15:0] LIMIT = 16'h00F0;
    localparam int          FW    = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FPUSH = 1;
    localparam int M_FPOP  = 2;
    localparam int M_DONE  = 3;

    logic        cpu_clock;
    logic        reset_n;
    logic        sp_load;
    logic        sp_store;
    logic        push;
    logic        pop;
    logic        frame_push_start;
    logic        frame_pop_start;
    logic        frame_ready;
    logic        fault_clear;
    wire  [15:0] addr_bus;
    logic [15:0] dut_sp;
    logic [15:0] stack_addr;
    logic [15:0] frame_addr;
    logic [1:0]  frame_idx;
    logic        frame_valid;
    logic        frame_write;
    logic        frame_done;
    logic        busy;
    logic        ovf;
    logic        udf;

    logic        bus_en;
    logic [15:0] bus_drv;

    assign addr_bus = bus_en ? bus_drv : 'z;

    k12a_stack_unit #(
        .WIDTH       (16),
        .STACK_BASE  (BASE),
        .STACK_LIMIT (LIMIT),
        .STEP        (1),
        .FRAME_WORDS (FW)
    ) dut (
        .cpu_clock        (cpu_clock),
        .reset_n          (reset_n),
        .sp_load          (sp_load),
        .sp_store         (sp_store),
        .push             (push),
        .pop              (pop),
        .frame_push_start (frame_push_start),
        .frame_pop_start  (frame_pop_start),
        .frame_ready      (frame_ready),
        .fault_clear      (fault_clear),
        .addr_bus         (addr_bus),
        .sp               (dut_sp),
        .stack_addr       (stack_addr),
        .frame_addr       (frame_addr),
        .frame_idx        (frame_idx),
        .frame_valid      (frame_valid),
        .frame_write      (frame_write),
        .frame_done       (frame_done),
        .busy             (busy),
        .ovf              (ovf),
        .udf              (udf)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        chk_en   = 1'b0;

    logic [15:0] m_sp;
    int          m_mode;
    int          m_idx;
    logic        m_ovf;
    logic        m_udf;
    logic [15:0] q_addr [FW];

    initial begin
        cpu_clock = 1'b0;
        forever #5 cpu_clock = ~cpu_clock;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: one call per rising edge, using this cycle's inputs.
    task automatic model_step();
        logic [15:0] room;
        logic [15:0] data;
        logic        ov;
        logic        ud;
        ov   = 1'b0;
        ud   = 1'b0;
        room = m_sp - LIMIT;
        data = BASE - m_sp;
        if (!reset_n) begin
            m_sp   = BASE;
            m_mode = M_IDLE;
            m_idx  = 0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            return;
        end
        if (fault_clear) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (sp_store) begin
            if (!sp_load) m_sp = bus_drv;
            m_mode = M_IDLE;
            m_idx  = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (frame_push_start) begin
                        if (room < 16'(FW)) ov = 1'b1;
                        else begin
                            for (int k = 0; k < FW; k++)
                                q_addr[k] = m_sp - 16'(k + 1);
                            m_mode = M_FPUSH;
                            m_idx  = 0;
                        end
                    end else if (frame_pop_start) begin
                        if (data < 16'(FW)) ud = 1'b1;
                        else begin
                            for (int k = 0; k < FW; k++)
                                q_addr[k] = m_sp + 16'(k);
                            m_mode = M_FPOP;
                            m_idx  = 0;
                        end
                    end else if (push && !pop) begin
                        if (room < 16'd1) ov = 1'b1;
                        else m_sp = m_sp - 16'd1;
                    end else if (pop && !push) begin
                        if (data < 16'd1) ud = 1'b1;
                        else m_sp = m_sp + 16'd1;
                    end
                end
                M_FPUSH, M_FPOP: begin
                    if (frame_ready) begin
                        m_sp = (m_mode == M_FPUSH) ? m_sp - 16'd1
                                                   : m_sp + 16'd1;
                        m_idx++;
                        if (m_idx == FW) begin
                            m_mode = M_DONE;
                            m_idx  = 0;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        if (ov) m_ovf = 1'b1;
        if (ud) m_udf = 1'b1;
    endtask

    task automatic compare();
        logic in_frame;
        in_frame = (m_mode == M_FPUSH) || (m_mode == M_FPOP);
        chk("sp", 32'(dut_sp), 32'(m_sp));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
        chk("frame_valid", 32'(frame_valid), 32'(in_frame));
        chk("frame_done", 32'(frame_done), 32'(m_mode == M_DONE));
        if (in_frame) begin
            chk("frame_addr", 32'(frame_addr), 32'(q_addr[m_idx]));
            chk("frame_write", 32'(frame_write), 32'(m_mode == M_FPUSH));
            chk("frame_idx", 32'(frame_idx), 32'(m_idx));
        end
        if (push ^ pop)
            chk("stack_addr", 32'(stack_addr),
                32'(push ? m_sp - 16'd1 : m_sp));
        if (sp_load && !bus_en)
            chk("addr_bus", 32'(addr_bus), 32'(m_sp));
    endtask

    initial begin
        forever begin
            @(negedge cpu_clock);
            if (chk_en) compare();
        end
    end

    task automatic cyc();
        @(posedge cpu_clock);
        model_step();
        #1;
    endtask

    task automatic store(input logic [15:0] v);
        sp_store = 1'b1;
        bus_en   = 1'b1;
        bus_drv  = v;
        cyc();
        sp_store = 1'b0;
        bus_en   = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        sp_load          = 1'b0;
        sp_store         = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;
        frame_push_start = 1'b0;
        frame_pop_start  = 1'b0;
        frame_ready      = 1'b0;
        fault_clear      = 1'b0;
        bus_en           = 1'b0;
        bus_drv          = 16'h0000;
        m_sp             = BASE;
        m_mode           = M_IDLE;
        m_idx            = 0;
        m_ovf            = 1'b0;
        m_udf            = 1'b0;
        for (int k = 0; k < FW; k++) q_addr[k] = 16'h0000;

        cyc();
        cyc();
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset state, pop on empty stack, flag clear
        chk("rst_sp", 32'(dut_sp), 32'h0100);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("udf_sp", 32'(dut_sp), 32'h0100);
        chk("udf_set", 32'(udf), 32'h1);
        chk("udf_ovf", 32'(ovf), 32'h0);
        fault_clear = 1'b1;
        cyc();
        fault_clear = 1'b0;
        chk("udf_clr", 32'(udf), 32'h0);

        // Three pushes, bus drive and release, one pop
        push = 1'b1;
        #1 chk("push_a0", 32'(stack_addr), 32'h00FF);
        cyc();
        chk("push_a1", 32'(stack_addr), 32'h00FE);
        cyc();
        chk("push_a2", 32'(stack_addr), 32'h00FD);
        cyc();
        push = 1'b0;
        chk("push_sp", 32'(dut_sp), 32'h00FD);
        sp_load = 1'b1;
        #1 chk("bus_drive", 32'(addr_bus), 32'h00FD);
        sp_load = 1'b0;
        bus_en  = 1'b1;
        bus_drv = 16'hFF02;
        #1 chk("bus_release", 32'(addr_bus), 32'hFF02);
        bus_en = 1'b0;
        pop = 1'b1;
        #1 chk("pop_addr", 32'(stack_addr), 32'h00FD);
        cyc();
        pop = 1'b0;
        chk("pop_sp", 32'(dut_sp), 32'h00FE);

        // Full stack overflow, push+pop collision
        store(16'h00F0);
        chk("store_sp", 32'(dut_sp), 32'h00F0);
        push = 1'b1;
        cyc();
        push = 1'b0;
        chk("ovf_set", 32'(ovf), 32'h1);
        chk("ovf_sp", 32'(dut_sp), 32'h00F0);
        fault_clear = 1'b1;
        cyc();
        fault_clear = 1'b0;
        push = 1'b1;
        pop  = 1'b1;
        cyc();
        push = 1'b0;
        pop  = 1'b0;
        chk("both_sp", 32'(dut_sp), 32'h00F0);
        chk("both_flags", 32'({ovf, udf}), 32'h0);

        // Frame push with a two-cycle stall on beat 1
        store(16'h0100);
        frame_ready      = 1'b1;
        frame_push_start = 1'b1;
        cyc();
        frame_push_start = 1'b0;
        chk("f0_valid", 32'(frame_valid), 32'h1);
        chk("f0_write", 32'(frame_write), 32'h1);
        chk("f0_addr", 32'(frame_addr), 32'h00FF);
        chk("f0_idx", 32'(frame_idx), 32'h0);
        cyc();
        frame_ready = 1'b0;
        chk("f1_addr", 32'(frame_addr), 32'h00FE);
        chk("f1_idx", 32'(frame_idx), 32'h1);
        cyc();
        chk("f1_hold_a", 32'(frame_addr), 32'h00FE);
        cyc();
        chk("f1_hold_b", 32'(frame_addr), 32'h00FE);
        chk("f1_hold_i", 32'(frame_idx), 32'h1);
        frame_ready = 1'b1;
        cyc();
        chk("f2_addr", 32'(frame_addr), 32'h00FD);
        chk("f2_idx", 32'(frame_idx), 32'h2);
        cyc();
        chk("f3_addr", 32'(frame_addr), 32'h00FC);
        chk("f3_idx", 32'(frame_idx), 32'h3);
        cyc();
        chk("fd_done", 32'(frame_done), 32'h1);
        chk("fd_busy", 32'(busy), 32'h1);
        chk("fd_valid", 32'(frame_valid), 32'h0);
        chk("fd_sp", 32'(dut_sp), 32'h00FC);
        cyc();
        chk("fi_busy", 32'(busy), 32'h0);
        chk("fi_done", 32'(frame_done), 32'h0);

        // Frame bound rejections
        store(16'h00F3);
        frame_push_start = 1'b1;
        cyc();
        frame_push_start = 1'b0;
        chk("fovf_flag", 32'(ovf), 32'h1);
        chk("fovf_busy", 32'(busy), 32'h0);
        fault_clear = 1'b1;
        cyc();
        fault_clear = 1'b0;
        store(16'h00FE);
        frame_pop_start = 1'b1;
        cyc();
        frame_pop_start = 1'b0;
        chk("fudf_flag", 32'(udf), 32'h1);
        chk("fudf_busy", 32'(busy), 32'h0);
        chk("fudf_sp", 32'(dut_sp), 32'h00FE);

        // Frame aborted by sp_store on beat 2
        store(16'h0100);
        frame_push_start = 1'b1;
        cyc();
        frame_push_start = 1'b0;
        cyc();
        cyc();
        chk("ab_idx", 32'(frame_idx), 32'h2);
        store(16'h00F8);
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_sp", 32'(dut_sp), 32'h00F8);
        chk("ab_done0", 32'(frame_done), 32'h0);
        cyc();
        chk("ab_done1", 32'(frame_done), 32'h0);

        // Frame aborted by reset on beat 1
        store(16'h0100);
        frame_push_start = 1'b1;
        cyc();
        frame_push_start = 1'b0;
        cyc();
        chk("rb_idx", 32'(frame_idx), 32'h1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("rb_sp", 32'(dut_sp), 32'h0100);
        chk("rb_busy", 32'(busy), 32'h0);
        chk("rb_valid", 32'(frame_valid), 32'h0);
        chk("rb_done", 32'(frame_done), 32'h0);
        chk("rb_idx0", 32'(frame_idx), 32'h0);
        chk("rb_flags", 32'({ovf, udf}), 32'h0);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            reset_n          = ($urandom_range(0, 199) != 0);
            sp_store         = ($urandom_range(0, 29) == 0);
            sp_load          = ($urandom_range(0, 4) == 0);
            bus_en           = sp_store && !sp_load;
            bus_drv          = LIMIT - 16'd2 + 16'($urandom_range(0, 20));
            fault_clear      = !sp_store && ($urandom_range(0, 19) == 0);
            push             = ($urandom_range(0, 2) == 0);
            pop              = ($urandom_range(0, 2) == 0);
            frame_push_start = ($urandom_range(0, 15) == 0);
            frame_pop_start  = ($urandom_range(0, 15) == 0);
            frame_ready      = ($urandom_range(0, 9) < 7);
            cyc();
        end

        reset_n          = 1'b1;
        sp_store         = 1'b0;
        sp_load          = 1'b0;
        bus_en           = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;
        frame_push_start = 1'b0;
        frame_pop_start  = 1'b0;
        fault_clear      = 1'b0;
        cyc();
        @(negedge cpu_clock);
        chk_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/k12a_stack_unit.md
Name: k12a_stack_unit

Overview:
Parametrised stack-pointer unit, successor to the plain SP register in the k12a core.
- Retains the SP register's tri-state addr_bus load/store path.
- Adds single-word push/pop with automatic pointer adjust.
- Adds bounds checking with sticky overflow/underflow flags.
- Adds a multi-word frame sequencer (interrupt/call frames) with a ready/valid handshake toward the memory interface.

Parameters:
WIDTH, 16, pointer/address width in bits
STACK_BASE, 16'h0000, empty-stack pointer value; sp reset value
STACK_LIMIT, 16'hF000, lowest legal pointer value (full stack); unsigned compare
STEP, 1, address units per stack word
FRAME_WORDS, 4, words per frame transfer; must be >= 2
Legality (elaboration assertion): STACK_LIMIT + FRAME_WORDS*STEP <= STACK_BASE, evaluated modulo 2^WIDTH as unsigned. The default STACK_BASE=0 with STACK_LIMIT=F000 is the wrapped top-of-memory case: empty = 0x0000, first push lands at 0xFFFF.

Ports:
cpu_clock  in  1  core clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset, sampled on cpu_clock rising edge
sp_load  in  1  drive sp onto addr_bus
sp_store  in  1  load sp from addr_bus
push  in  1  single-word push request (1-cycle pulse)
pop  in  1  single-word pop request (1-cycle pulse)
frame_push_start  in  1  begin FRAME_WORDS-word push
frame_pop_start  in  1  begin FRAME_WORDS-word pop
frame_ready  in  1  memory accepts current frame beat
fault_clear  in  1  clear sticky flags
addr_bus  inout  WIDTH  shared address bus; Z unless sp_load
sp  out  WIDTH  current stack pointer
stack_addr  out  WIDTH  address of the word touched by this cycle's push/pop
frame_addr  out  WIDTH  address of current frame beat
frame_idx  out  $clog2(FRAME_WORDS)  beat index
frame_valid  out  1  frame beat presented
frame_write  out  1  1 = push frame, 0 = pop frame
frame_done  out  1  1-cycle pulse after last beat accepted
busy  out  1  frame in progress
ovf  out  1  sticky overflow
udf  out  1  sticky underflow

Behaviour:
- Reset (reset_n=0 at a rising edge) sets: sp=STACK_BASE, state IDLE, ovf=udf=0, frame_valid=0, frame_done=0, busy=0, frame_idx=0. Reset mid-frame aborts the frame with no done pulse.
- addr_bus = sp_load ? sp : Z, combinational, legal in any state.
- Priority per edge: reset > sp_store > fault_clear/flag set > frame FSM > push/pop.
- sp_store loads addr_bus the next edge. If busy, it aborts the frame: state goes IDLE, no frame_done.
- Growth is downward.
  - push: stack_addr = sp - STEP (combinational); next edge sp <= sp - STEP (pre-decrement).
  - pop: stack_addr = sp; next edge sp <= sp + STEP (post-increment).
  - stack_addr is don't-care when neither push nor pop is asserted.
- Bounds (unsigned, computed as sp - STACK_LIMIT and STACK_BASE - sp modulo 2^WIDTH):
  - push with sp - STACK_LIMIT < STEP: sp unchanged, ovf <= 1.
  - pop with STACK_BASE - sp < STEP (includes sp == STACK_BASE): sp unchanged, udf <= 1.
  - The pointer never wraps past either bound.
- push and pop in the same cycle: both ignored, no flag change.
- push, pop and frame starts are ignored while busy.
- fault_clear clears both flags. A fault set on the same edge wins, so the flag stays 1.
- Frame FSM states: IDLE, FPUSH, FPOP, DONE.
  - IDLE + frame_push_start: if sp - STACK_LIMIT < FRAME_WORDS*STEP, set ovf and stay IDLE; else go to FPUSH with idx=0.
  - IDLE + frame_pop_start: if STACK_BASE - sp < FRAME_WORDS*STEP, set udf and stay IDLE; else go to FPOP with idx=0.
  - Both starts asserted: push wins.
  - FPUSH: frame_valid=1, frame_write=1, frame_addr = sp - STEP. On frame_ready: sp -= STEP, idx++.
  - FPOP: frame_valid=1, frame_write=0, frame_addr = sp. On frame_ready: sp += STEP, idx++.
  - frame_ready low: all frame outputs hold.
  - Beat idx == FRAME_WORDS-1 accepted: go to DONE.
  - DONE lasts one cycle: frame_done=1, busy=1, frame_valid=0; then IDLE.
  - busy = (state != IDLE).
- Latency:
  - push/pop: sp updates 1 edge after the request.
  - Frame with no stalls: FRAME_WORDS+1 edges from start to IDLE.
- All pointer arithmetic is WIDTH-bit, modulo 2^WIDTH.

Decomposition:
- k12a.inc.sv gains the stack_state_t enum {IDLE, FPUSH, FPOP, DONE}.
- Sub-module k12a_stack_bounds: combinational bound checker.
  - Inputs: sp, word count.
  - Outputs: room_ok, data_ok.
  - Instanced twice: single-word check and frame check.

Test Plan:
(WIDTH=16, STACK_BASE=0x0100, STACK_LIMIT=0x00F0, STEP=1, FRAME_WORDS=4)
1. Reset, then pop -> sp=0x0100, udf=1, ovf=0; fault_clear -> udf=0.
2. Push x3 -> stack_addr 0x00FF, 0x00FE, 0x00FD; sp=0x00FD. sp_load -> addr_bus=0x00FD, else Z. Pop -> stack_addr=0x00FD, sp=0x00FE.
3. sp_store with addr_bus=0x00F0, then push -> ovf=1, sp stays 0x00F0. Push+pop in same cycle -> no change.
4. sp=0x0100, frame_push_start, frame_ready low on beat 1 for 2 cycles:
   - frame_addr sequence 0x00FF, 0x00FE (held 2 cycles), 0x00FD, 0x00FC; idx 0..3.
   - frame_done pulses once; sp=0x00FC; busy drops the following cycle.
5. sp=0x00F3, frame_push_start -> ovf=1, busy stays 0. sp=0x00FE, frame_pop_start -> udf=1, busy stays 0.
6. Interrupted frame push from 0x0100:
   - sp_store with addr_bus=0x00F8 during beat 2 -> state IDLE, sp=0x00F8, no frame_done.
   - Repeat, with reset_n low during beat 1 -> sp=0x0100, all outputs at reset values.
